// File: rtl/edge_detect_pkg.sv
// Shared types and helpers for the pong boundary/contact detector.
// Optional build macro: EDGE_DETECT_PADDLE_BLOCK_EN (see edge_detect.sv).
package edge_detect_pkg;

    localparam int H_RES_DEF         = 640;
    localparam int V_RES_DEF         = 480;
    localparam int BALL_MARGIN_DEF   = 4;
    localparam int PADDLE_MARGIN_DEF = 6;
    localparam int HIT_MARGIN_DEF    = 4;

    localparam int EDGE_BOTTOM = 0;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_LEFT   = 3;

    typedef struct packed {
        logic signed [31:0] size_x;
        logic signed [31:0] size_y;
        logic signed [31:0] ini_x;
        logic signed [31:0] ini_y;
        logic signed [31:0] off_x;
        logic signed [31:0] off_y;
    } rect_t;

    // 34 bits hold ini+off+size of three signed 32-bit values without wrap
    typedef logic signed [33:0] coord_t;

    typedef struct packed {
        coord_t l;
        coord_t r;
        coord_t t;
        coord_t b;
    } box_t;

    function automatic box_t rect_to_box(input rect_t rc);
        box_t bx;
        bx.l = coord_t'($signed(rc.ini_x)) + coord_t'($signed(rc.off_x));
        bx.t = coord_t'($signed(rc.ini_y)) + coord_t'($signed(rc.off_y));
        bx.r = bx.l + coord_t'($signed(rc.size_x));
        bx.b = bx.t + coord_t'($signed(rc.size_y));
        return bx;
    endfunction

    function automatic logic [3:0] room(
        input box_t   bx,
        input coord_t m,
        input coord_t h,
        input coord_t v
    );
        logic [3:0] e;
        e              = '0;
        e[EDGE_BOTTOM] = (bx.b + m) <= v;
        e[EDGE_RIGHT]  = (bx.r + m) <= h;
        e[EDGE_TOP]    = (bx.t - m) >= coord_t'(0);
        e[EDGE_LEFT]   = (bx.l - m) >= coord_t'(0);
        return e;
    endfunction

endpackage

// File: rtl/edge_detect_contact.sv
// Combinational ball-vs-paddle side contact test.
// Bit order matches the edge encoding: bottom, right, top, left of the ball.
module edge_contact
    import edge_detect_pkg::*;
#(
    parameter int HIT_MARGIN = HIT_MARGIN_DEF
) (
    input  rect_t      ball_i,
    input  rect_t      paddle_i,
    output logic [3:0] contact_o
);

    localparam coord_t HIT = coord_t'(HIT_MARGIN);

    box_t bb;
    box_t pb;
    logic ovh;
    logic ovv;

    always_comb begin
        bb  = rect_to_box(ball_i);
        pb  = rect_to_box(paddle_i);
        ovh = (bb.l < pb.r) && (pb.l < bb.r);
        ovv = (bb.t < pb.b) && (pb.t < bb.b);

        contact_o = '0;
        contact_o[EDGE_BOTTOM] = ovh && (bb.b >= pb.t - HIT)
                                     && (bb.t < pb.t);
        contact_o[EDGE_RIGHT]  = ovv && (bb.r >= pb.l - HIT)
                                     && (bb.l < pb.l);
        contact_o[EDGE_TOP]    = ovh && (bb.t <= pb.b + HIT)
                                     && (bb.b > pb.b);
        contact_o[EDGE_LEFT]   = ovv && (bb.l <= pb.r + HIT)
                                     && (bb.r > pb.r);
    end

endmodule

// File: rtl/edge_detect.sv
// Registered screen-edge and ball/paddle contact detector (t_clk domain).
// Macro EDGE_DETECT_PADDLE_BLOCK_EN: paddle contacts also block ball motion.
module edge_detect
    import edge_detect_pkg::*;
#(
    parameter int H_RES         = H_RES_DEF,
    parameter int V_RES         = V_RES_DEF,
    parameter int BALL_MARGIN   = BALL_MARGIN_DEF,
    parameter int PADDLE_MARGIN = PADDLE_MARGIN_DEF,
    parameter int HIT_MARGIN    = HIT_MARGIN_DEF
) (
    input  logic               t_clk,
    input  logic               reset,
    input  logic signed [31:0] ball_size_x,
    input  logic signed [31:0] ball_size_y,
    input  logic signed [31:0] ball_ini_x,
    input  logic signed [31:0] ball_ini_y,
    input  logic signed [31:0] ball_off_x,
    input  logic signed [31:0] ball_off_y,
    input  logic signed [31:0] paddle_R_size_x,
    input  logic signed [31:0] paddle_R_size_y,
    input  logic signed [31:0] paddle_R_ini_x,
    input  logic signed [31:0] paddle_R_ini_y,
    input  logic signed [31:0] paddle_R_off_x,
    input  logic signed [31:0] paddle_R_off_y,
    input  logic signed [31:0] paddle_L_size_x,
    input  logic signed [31:0] paddle_L_size_y,
    input  logic signed [31:0] paddle_L_ini_x,
    input  logic signed [31:0] paddle_L_ini_y,
    input  logic signed [31:0] paddle_L_off_x,
    input  logic signed [31:0] paddle_L_off_y,
    output logic [3:0]         ball_detect_edge,
    output logic [3:0]         paddle_R_detect_edge,
    output logic [3:0]         paddle_L_detect_edge,
    output logic [7:0]         collision_detect
);

    localparam coord_t H_C  = coord_t'(H_RES);
    localparam coord_t V_C  = coord_t'(V_RES);
    localparam coord_t BM_C = coord_t'(BALL_MARGIN);
    localparam coord_t PM_C = coord_t'(PADDLE_MARGIN);

    rect_t ball_r;
    rect_t pad_r_r;
    rect_t pad_l_r;

    assign ball_r = '{
        size_x: ball_size_x, size_y: ball_size_y,
        ini_x:  ball_ini_x,  ini_y:  ball_ini_y,
        off_x:  ball_off_x,  off_y:  ball_off_y
    };
    assign pad_r_r = '{
        size_x: paddle_R_size_x, size_y: paddle_R_size_y,
        ini_x:  paddle_R_ini_x,  ini_y:  paddle_R_ini_y,
        off_x:  paddle_R_off_x,  off_y:  paddle_R_off_y
    };
    assign pad_l_r = '{
        size_x: paddle_L_size_x, size_y: paddle_L_size_y,
        ini_x:  paddle_L_ini_x,  ini_y:  paddle_L_ini_y,
        off_x:  paddle_L_off_x,  off_y:  paddle_L_off_y
    };

    logic [3:0] col_r;
    logic [3:0] col_l;

    edge_contact #(
        .HIT_MARGIN (HIT_MARGIN)
    ) u_contact_r (
        .ball_i    (ball_r),
        .paddle_i  (pad_r_r),
        .contact_o (col_r)
    );

    edge_contact #(
        .HIT_MARGIN (HIT_MARGIN)
    ) u_contact_l (
        .ball_i    (ball_r),
        .paddle_i  (pad_l_r),
        .contact_o (col_l)
    );

    logic [3:0] ball_edge_d,  ball_edge_q;
    logic [3:0] pad_r_edge_d, pad_r_edge_q;
    logic [3:0] pad_l_edge_d, pad_l_edge_q;
    logic [7:0] col_d,        col_q;

    always_comb begin
        col_d        = {col_l, col_r};
        pad_r_edge_d = room(rect_to_box(pad_r_r), PM_C, H_C, V_C);
        pad_l_edge_d = room(rect_to_box(pad_l_r), PM_C, H_C, V_C);
`ifdef EDGE_DETECT_PADDLE_BLOCK_EN
        // a touching paddle side acts like a wall for the ball
        ball_edge_d  = room(rect_to_box(ball_r), BM_C, H_C, V_C)
                     & ~(col_r | col_l);
`else
        ball_edge_d  = room(rect_to_box(ball_r), BM_C, H_C, V_C);
`endif
    end

    always_ff @(posedge t_clk) begin
        if (reset) begin
            ball_edge_q  <= 4'b0000;
            pad_r_edge_q <= 4'b0000;
            pad_l_edge_q <= 4'b0000;
            col_q        <= 8'h00;
        end else begin
            ball_edge_q  <= ball_edge_d;
            pad_r_edge_q <= pad_r_edge_d;
            pad_l_edge_q <= pad_l_edge_d;
            col_q        <= col_d;
        end
    end

    assign ball_detect_edge     = ball_edge_q;
    assign paddle_R_detect_edge = pad_r_edge_q;
    assign paddle_L_detect_edge = pad_l_edge_q;
    assign collision_detect     = col_q;

endmodule

// File: tb/tb_edge_detect.sv
// Directed-vector bench for edge_detect.
// Honours EDGE_DETECT_PADDLE_BLOCK_EN when choosing ball-edge expectations.
module tb_edge_detect;

    logic t_clk;
    logic reset;
    logic signed [31:0] b_sx, b_sy, b_ix, b_iy, b_ox, b_oy;
    logic signed [31:0] r_sx, r_sy, r_ix, r_iy, r_ox, r_oy;
    logic signed [31:0] l_sx, l_sy, l_ix, l_iy, l_ox, l_oy;
    logic [3:0] ball_e, pad_r_e, pad_l_e;
    logic [7:0] col;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef EDGE_DETECT_PADDLE_BLOCK_EN
    localparam logic [3:0] EXP_HIT_R  = 4'b1101;
    localparam logic [3:0] EXP_HIT_L  = 4'b0111;
    localparam logic [3:0] EXP_MULTI  = 4'b0001;
`else
    localparam logic [3:0] EXP_HIT_R  = 4'b1111;
    localparam logic [3:0] EXP_HIT_L  = 4'b1111;
    localparam logic [3:0] EXP_MULTI  = 4'b1111;
`endif

    edge_detect dut (
        .t_clk                (t_clk),
        .reset                (reset),
        .ball_size_x          (b_sx),
        .ball_size_y          (b_sy),
        .ball_ini_x           (b_ix),
        .ball_ini_y           (b_iy),
        .ball_off_x           (b_ox),
        .ball_off_y           (b_oy),
        .paddle_R_size_x      (r_sx),
        .paddle_R_size_y      (r_sy),
        .paddle_R_ini_x       (r_ix),
        .paddle_R_ini_y       (r_iy),
        .paddle_R_off_x       (r_ox),
        .paddle_R_off_y       (r_oy),
        .paddle_L_size_x      (l_sx),
        .paddle_L_size_y      (l_sy),
        .paddle_L_ini_x       (l_ix),
        .paddle_L_ini_y       (l_iy),
        .paddle_L_off_x       (l_ox),
        .paddle_L_off_y       (l_oy),
        .ball_detect_edge     (ball_e),
        .paddle_R_detect_edge (pad_r_e),
        .paddle_L_detect_edge (pad_l_e),
        .collision_detect     (col)
    );

    initial t_clk = 1'b0;
    always #5 t_clk = ~t_clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge t_clk);
        #1;
    endtask

    task automatic check_all(
        input string      tag,
        input logic [3:0] eb,
        input logic [3:0] er,
        input logic [3:0] el,
        input logic [7:0] ec
    );
        check({tag, ".ball"}, 32'(ball_e),  32'(eb));
        check({tag, ".padR"}, 32'(pad_r_e), 32'(er));
        check({tag, ".padL"}, 32'(pad_l_e), 32'(el));
        check({tag, ".col"},  32'(col),     32'(ec));
    endtask

    task automatic home();
        b_sx = 25;  b_sy = 25;  b_ix = 269; b_iy = 189; b_ox = 0; b_oy = 0;
        r_sx = 10;  r_sy = 150; r_ix = 600; r_iy = 100; r_ox = 0; r_oy = 0;
        l_sx = 10;  l_sy = 150; l_ix = 40;  l_iy = 189; l_ox = 0; l_oy = 0;
    endtask

    initial begin
        reset = 1'b1;
        home();
        b_ox = 306;

        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("reset", 4'b0000, 4'b0000, 4'b0000, 8'h00);
        end

        home();
        reset = 1'b0;
        tick();
        check_all("rel", 4'b1111, 4'b1111, 4'b1111, 8'h00);

        b_oy = 262;
        tick();
        check("ball_bot_fit", 32'(ball_e), 32'(4'b1111));
        b_oy = 263;
        tick();
        check("ball_bot_block", 32'(ball_e), 32'(4'b1110));
        b_oy = 0;
        b_ox = -265;
        tick();
        check("ball_left_fit", 32'(ball_e), 32'(4'b1111));
        b_ox = -266;
        tick();
        check("ball_left_block", 32'(ball_e), 32'(4'b0111));
        b_ox = -300;
        tick();
        check_all("ball_neg", 4'b0111, 4'b1111, 4'b1111, 8'h00);
        b_ox = 0;

        r_oy = 230;
        tick();
        check("padR_bottom", 32'(pad_r_e), 32'(4'b1110));
        r_oy = -100;
        tick();
        check("padR_top", 32'(pad_r_e), 32'(4'b1011));
        r_oy = 0;
        tick();
        check("padR_rest", 32'(pad_r_e), 32'(4'b1111));

        b_ox = 306;
        tick();
        check_all("hitR", EXP_HIT_R, 4'b1111, 4'b1111, 8'h02);

        b_ox = -219;
        tick();
        check_all("hitL", EXP_HIT_L, 4'b1111, 4'b1111, 8'h80);

        b_ox = 325;
        b_oy = 60;
        tick();
        check_all("multi", EXP_MULTI, 4'b1111, 4'b1111, 8'h0E);

        b_ox = 306;
        b_oy = 0;
        reset = 1'b1;
        tick();
        check_all("midrst", 4'b0000, 4'b0000, 4'b0000, 8'h00);
        reset = 1'b0;
        tick();
        check_all("after_rst", EXP_HIT_R, 4'b1111, 4'b1111, 8'h02);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
